mux_30_to_1_5bits_serializer: RTL and testbench
===============================================

Name: mux_30_to_1_5bits_serializer

Overview:
- Gathering counterpart of the 1-to-30 5-bit demux fabric.
- On a start pulse, snapshots 30 parallel 5-bit channel words into an internal buffer.
- Then streams the words one at a time, channel 1 first, over a valid/ready interface.
- Each word carries a 5-bit channel index that can drive a downstream demux sel.

Parameters:
- DATA_WIDTH, 5, width of each channel word.
- NUM_CH, 30, number of channels; fixed at 30 for this instance.
- SEL_WIDTH, 5, width of the channel index; must satisfy 2^SEL_WIDTH >= NUM_CH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to capture all channels and begin streaming.
- din_1 .. din_30  input  5 each  parallel channel words; sampled only in the start capture cycle.
- dout  output  5  current streamed word.
- sel  output  5  channel index of dout; 0 means din_1, 29 means din_30.
- out_valid  output  1  dout and sel are valid.
- out_ready  input  1  consumer accepts the word when high together with out_valid.
- busy  output  1  high from capture until the last word transfers.
- done  output  1  one-cycle pulse in the cycle after the last transfer.

Behaviour:
- Reset is synchronous, active-high. On reset: state=IDLE, dout=0, sel=0, out_valid=0, busy=0, done=0, index counter=0. Buffer contents are don't-care.
- States:
  - IDLE -> SEND when start=1. In that edge, all 30 din_k are registered into buf[k-1], index is set to 0, busy=1, out_valid=1.
  - SEND -> SEND on a transfer (out_valid & out_ready) while index<29. index increments by 1.
  - SEND -> FIN on a transfer while index==29. out_valid=0, busy=0, done=1.
  - FIN -> IDLE unconditionally after one cycle. done returns to 0.
- Datapath: dout = buf[index], sel = index. Both are registered and update in the same edge as index.
- Latency: start sampled at edge N gives out_valid=1, sel=0, dout=din_1 (as sampled at N), all visible after edge N.
- Throughput: one word per cycle with out_ready held high. A full frame takes 30 transfer cycles, followed by done one cycle later.
- Backpressure: while out_valid=1 and out_ready=0, dout, sel and out_valid hold stable. Stalls of any length are allowed.
- Snapshot rule: din changes after the capture edge do not affect the words being streamed.
- start while busy (SEND) or in FIN is ignored; no re-capture and no error flag.
- start in IDLE in the same cycle that FIN exits is not possible, because FIN always lasts one cycle. start asserted during FIN is dropped.
- Index is only 0..29; it never wraps to 30/31 and never exceeds 29.
- Reset mid-frame: the next edge forces IDLE. Remaining words are discarded, out_valid drops and done is not pulsed.
- done and out_valid are never high in the same cycle.

Test Plan:
- Basic frame: reset 2 cycles, din_k=k (din_1=1 .. din_30=30), start pulse, out_ready=1 -> 30 consecutive transfers with sel=0..29 and dout=1..30; done pulses exactly once, one cycle after the sel=29 transfer; busy is high for 30 cycles.
- Backpressure: same stimulus, out_ready toggles 1,0,0,1 repeating -> dout/sel held stable during stalls; sequence still 1..30 with no duplicates or drops; done appears after the 30th transfer.
- Snapshot: din_k=5'h1F at start, then all din_k=0 the next cycle -> all 30 streamed words equal 5'h1F.
- start while busy: second start at transfer 10 with din_k=0 -> streaming continues with original values 11..30; only one done pulse.
- Reset mid-frame: assert reset after transfer 15 with out_ready=1 -> out_valid=0, busy=0, done=0, sel=0, dout=0 on the next edge; a new start then produces a full 30-word frame from sel=0.
- Boundary: out_ready=0 from capture for 50 cycles, then 1 -> sel=0, dout=din_1 held for all 50 cycles; last word sel=29 is followed by done, then IDLE.

Source files
------------

// File: rtl/mux_30_to_1_5bits_serializer.sv
// mux_30_to_1_5bits_serializer: snapshots 30 channel words on start and streams them out over valid/ready, channel 1 first
// Ports: clk, reset (sync, active-high), start (capture request), din_1..din_30 (channel words),
//        dout/sel (streamed word and its channel index), out_valid/out_ready (handshake),
//        busy (capture until last transfer), done (pulse after last transfer)
module mux_30_to_1_5bits_serializer #(
  parameter int DATA_WIDTH = 5,
  parameter int NUM_CH = 30,
  parameter int SEL_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] din_1,
  input  logic [DATA_WIDTH-1:0] din_2,
  input  logic [DATA_WIDTH-1:0] din_3,
  input  logic [DATA_WIDTH-1:0] din_4,
  input  logic [DATA_WIDTH-1:0] din_5,
  input  logic [DATA_WIDTH-1:0] din_6,
  input  logic [DATA_WIDTH-1:0] din_7,
  input  logic [DATA_WIDTH-1:0] din_8,
  input  logic [DATA_WIDTH-1:0] din_9,
  input  logic [DATA_WIDTH-1:0] din_10,
  input  logic [DATA_WIDTH-1:0] din_11,
  input  logic [DATA_WIDTH-1:0] din_12,
  input  logic [DATA_WIDTH-1:0] din_13,
  input  logic [DATA_WIDTH-1:0] din_14,
  input  logic [DATA_WIDTH-1:0] din_15,
  input  logic [DATA_WIDTH-1:0] din_16,
  input  logic [DATA_WIDTH-1:0] din_17,
  input  logic [DATA_WIDTH-1:0] din_18,
  input  logic [DATA_WIDTH-1:0] din_19,
  input  logic [DATA_WIDTH-1:0] din_20,
  input  logic [DATA_WIDTH-1:0] din_21,
  input  logic [DATA_WIDTH-1:0] din_22,
  input  logic [DATA_WIDTH-1:0] din_23,
  input  logic [DATA_WIDTH-1:0] din_24,
  input  logic [DATA_WIDTH-1:0] din_25,
  input  logic [DATA_WIDTH-1:0] din_26,
  input  logic [DATA_WIDTH-1:0] din_27,
  input  logic [DATA_WIDTH-1:0] din_28,
  input  logic [DATA_WIDTH-1:0] din_29,
  input  logic [DATA_WIDTH-1:0] din_30,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [SEL_WIDTH-1:0]  sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] din [NUM_CH];
  logic [DATA_WIDTH-1:0] mem [NUM_CH];
  logic cap, xfer, last;
  assign din = '{din_1, din_2, din_3, din_4, din_5, din_6, din_7, din_8, din_9, din_10,
                 din_11, din_12, din_13, din_14, din_15, din_16, din_17, din_18, din_19, din_20,
                 din_21, din_22, din_23, din_24, din_25, din_26, din_27, din_28, din_29, din_30};
  always_comb begin
    cap = (state == IDLE) && start;
    xfer = (state == SEND) && out_ready;
    last = sel == SEL_WIDTH'(NUM_CH - 1);
    state_n = state == IDLE ? (start ? SEND : IDLE) :
              state == SEND ? (xfer && last ? FIN : SEND) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sel <= '0;
      dout <= '0;
    end else begin
      state <= state_n;
      if (cap) begin
        sel <= '0;
        dout <= din[0];
      end else if (xfer && !last) begin
        sel <= sel + 1'b1;
        dout <= mem[sel + 1'b1];
      end
    end
  end
  always_ff @(posedge clk) if (cap) mem <= din;
  assign out_valid = state == SEND;
  assign busy = state == SEND;
  assign done = state == FIN;
endmodule

// File: tb/tb_mux_30_to_1_5bits_serializer.sv
// tb_mux_30_to_1_5bits_serializer: directed and random frames checked against a queue-based reference model
module tb_mux_30_to_1_5bits_serializer;
  logic clk = 0, reset = 1, start = 0, out_ready = 0;
  logic [4:0] d [30];
  logic [4:0] dout, sel;
  logic out_valid, busy, done;
  int checks = 0, failures = 0;
  logic [4:0] q [$];
  logic [4:0] m_dout = 0, m_sel = 0;
  logic m_done = 0;
  always #5 clk = ~clk;
  mux_30_to_1_5bits_serializer dut (
    .clk(clk), .reset(reset), .start(start),
    .din_1(d[0]), .din_2(d[1]), .din_3(d[2]), .din_4(d[3]), .din_5(d[4]),
    .din_6(d[5]), .din_7(d[6]), .din_8(d[7]), .din_9(d[8]), .din_10(d[9]),
    .din_11(d[10]), .din_12(d[11]), .din_13(d[12]), .din_14(d[13]), .din_15(d[14]),
    .din_16(d[15]), .din_17(d[16]), .din_18(d[17]), .din_19(d[18]), .din_20(d[19]),
    .din_21(d[20]), .din_22(d[21]), .din_23(d[22]), .din_24(d[23]), .din_25(d[24]),
    .din_26(d[25]), .din_27(d[26]), .din_28(d[27]), .din_29(d[28]), .din_30(d[29]),
    .dout(dout), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic set_din(input int mode);
    for (int i = 0; i < 30; i++) d[i] = mode == 0 ? 5'(i + 1) : mode == 1 ? 5'h1F : mode == 2 ? 5'd0 : 5'($urandom);
  endtask
  // The model holds the words still owed to the consumer; the head is what dout must show.
  task automatic step();
    if (reset) begin
      q.delete();
      m_done = 0;
      m_sel = 0;
      m_dout = 0;
    end else if (m_done) m_done = 0;
    else if (q.size() == 0) begin
      if (start) begin
        for (int i = 0; i < 30; i++) q.push_back(d[i]);
        m_sel = 0;
        m_dout = q[0];
      end
    end else if (out_ready) begin
      void'(q.pop_front());
      if (q.size() == 0) m_done = 1;
      else begin
        m_sel = 5'(30 - q.size());
        m_dout = q[0];
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, q.size() != 0);
    chk("busy", busy, q.size() != 0);
    chk("done", done, m_done);
    chk("sel", sel, m_sel);
    chk("dout", dout, m_dout);
    chk("done_valid_excl", done & out_valid, 0);
  endtask
  task automatic pulse_start();
    start = 1;
    step();
    start = 0;
  endtask
  task automatic drain(input int mode);
    for (int c = 0; c < 400 && (q.size() != 0 || m_done); c++) begin
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? ((c % 4) == 0 || (c % 4) == 3) : 1'($urandom);
      step();
    end
    out_ready = 1;
    step();
  endtask
  initial begin
    set_din(0);
    reset = 1;
    step();
    step();
    reset = 0;
    out_ready = 1;
    pulse_start();
    drain(0);
    set_din(0);
    out_ready = 1;
    pulse_start();
    drain(1);
    set_din(1);
    pulse_start();
    set_din(2);
    drain(0);
    set_din(0);
    pulse_start();
    for (int c = 0; c < 40 && q.size() > 20; c++) step();
    set_din(2);
    pulse_start();
    drain(0);
    set_din(0);
    pulse_start();
    for (int c = 0; c < 40 && q.size() > 15; c++) step();
    reset = 1;
    step();
    reset = 0;
    step();
    pulse_start();
    drain(0);
    set_din(3);
    out_ready = 0;
    pulse_start();
    for (int c = 0; c < 49; c++) step();
    drain(0);
    for (int f = 0; f < 6; f++) begin
      set_din(3);
      out_ready = 1'($urandom);
      for (int c = 0; c < 4; c++) begin
        start = 1'($urandom);
        step();
      end
      start = 0;
      pulse_start();
      drain(2);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
